// File: rtl/fc_stream_tx_pkg.sv
// Shared constants, state encoding and byte-swap helper for the FC stream transmitter.
package fc_stream_pkg;

    localparam int unsigned InputSize  = 8;
    localparam int unsigned OutputSize = 4;
    localparam int unsigned WeightSize = InputSize * OutputSize;
    localparam int unsigned NWords     = (InputSize + WeightSize + OutputSize) / 4;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StSend    = 2'd1;
    localparam logic [1:0] StTail    = 2'd2;
    localparam logic [1:0] StWaitRsp = 2'd3;

    // Reverse byte order; the controller word bus is little-endian, host packing big-endian.
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/fc_stream_tx_if.sv
// Host and controller-facing signal bundle of the FC stream transmitter.
interface fc_stream_tx_if #(
    parameter int unsigned INPUT_SIZE  = fc_stream_pkg::InputSize,
    parameter int unsigned OUTPUT_SIZE = fc_stream_pkg::OutputSize
) ();
    localparam int unsigned WEIGHT_SIZE = INPUT_SIZE * OUTPUT_SIZE;

    logic                       start;
    logic [INPUT_SIZE*8-1:0]    in_vec;
    logic [WEIGHT_SIZE*8-1:0]   weight;
    logic [OUTPUT_SIZE*8-1:0]   bias;
    logic                       busy;
    logic                       r_valid;
    logic [31:0]                in_data;
    logic [31:0]                out_data;
    logic                       t_valid;
    logic                       done;
    logic [OUTPUT_SIZE*8-1:0]   result;
    logic                       timeout;

    // Host plus controller side: drives operands and responses, observes the stream.
    modport master (
        output start, in_vec, weight, bias, out_data, t_valid,
        input  busy, r_valid, in_data, done, result, timeout
    );

    // Transmitter side.
    modport slave (
        input  start, in_vec, weight, bias, out_data, t_valid,
        output busy, r_valid, in_data, done, result, timeout
    );
endinterface

// File: rtl/fc_stream_tx_rsp_capture.sv
// Response wait: counts WAIT_RSP cycles, captures the result word or flags a timeout.
module fc_stream_rsp_capture import fc_stream_pkg::*; #(
    parameter int unsigned OUTPUT_SIZE = OutputSize,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     active_i,   // FSM is in WAIT_RSP
    input  logic                     clear_i,    // new frame accepted
    input  logic                     t_valid_i,
    input  logic [31:0]              out_data_i,
    output logic                     finish_o,   // leave WAIT_RSP this cycle
    output logic                     done_o,
    output logic [OUTPUT_SIZE*8-1:0] result_o,
    output logic                     timeout_o
);
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned ResW = OUTPUT_SIZE * 8;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            done_q;
    logic [ResW-1:0] result_q, result_d;
    logic            timeout_q, timeout_d;
    logic            expire;

    // Wait counter, expiry decision and next values of the captured outputs.
    always_comb begin
        expire   = active_i && (cnt_q == CntW'(TIMEOUT_CYC - 1));
        finish_o = active_i && (t_valid_i || expire);
        cnt_d    = '0;
        if (active_i) begin
            cnt_d = (cnt_q == CntW'(TIMEOUT_CYC)) ? cnt_q : cnt_q + 1'b1;
        end
        result_d = result_q;
        if (active_i && t_valid_i) begin
            // Wider results carry the single captured word in the low bytes.
            result_d = ResW'(bswap32(out_data_i));
        end
        timeout_d = timeout_q;
        if (clear_i) begin
            timeout_d = 1'b0;
        end else if (expire && !t_valid_i) begin
            timeout_d = 1'b1;
        end
    end

    // Registered done pulse, result and sticky timeout.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            done_q    <= 1'b0;
            result_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            done_q    <= finish_o;
            result_q  <= result_d;
            timeout_q <= timeout_d;
        end
    end

    assign done_o    = done_q;
    assign result_o  = result_q;
    assign timeout_o = timeout_q;

endmodule

// File: rtl/fc_stream_tx.sv
// Serialises one FC frame onto the controller word stream and collects its result.
module fc_stream_tx import fc_stream_pkg::*; #(
    parameter int unsigned INPUT_SIZE  = InputSize,
    parameter int unsigned OUTPUT_SIZE = OutputSize,
    parameter int unsigned TAIL_CYCLES = 1,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input logic          clk_i,
    input logic          rst_i,
    fc_stream_tx_if.slave bus
);
    localparam int unsigned WSize  = INPUT_SIZE * OUTPUT_SIZE;
    localparam int unsigned NW     = (INPUT_SIZE + WSize + OUTPUT_SIZE) / 4;
    localparam int unsigned FrameW = NW * 32;
    localparam int unsigned IdxW   = (NW > 1) ? $clog2(NW) : 1;
    localparam int unsigned TailW  = (TAIL_CYCLES > 1) ? $clog2(TAIL_CYCLES) : 1;
    localparam logic [IdxW-1:0]  IdxLast  = IdxW'(NW - 1);
    localparam logic [TailW-1:0] TailLast = TailW'((TAIL_CYCLES == 0) ? 0 : TAIL_CYCLES - 1);

    logic [1:0]        state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [TailW-1:0]  tail_q, tail_d;
    logic [FrameW-1:0] frame_q, frame_d;
    logic [31:0]       word_sel;
    logic              start_acc;
    logic              stream_on;
    logic              rsp_finish;

    // Word mux: word 0 is the most-significant slice of the frame.
    always_comb begin
        word_sel = '0;
        for (int k = 0; k < int'(NW); k++) begin
            if (idx_q == IdxW'(k)) begin
                word_sel = frame_q[FrameW-1-32*k -: 32];
            end
        end
    end

    // Frame sequencing: accept, stream words, hold tail, wait for response.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tail_d    = tail_q;
        frame_d   = frame_q;
        start_acc = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    frame_d   = {bus.in_vec, bus.weight, bus.bias};
                    idx_d     = '0;
                    start_acc = 1'b1;
                    state_d   = StSend;
                end
            end
            StSend: begin
                if (idx_q == IdxLast) begin
                    tail_d  = '0;
                    state_d = (TAIL_CYCLES == 0) ? StWaitRsp : StTail;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StTail: begin
                if (tail_q == TailLast) begin
                    state_d = StWaitRsp;
                end else begin
                    tail_d = tail_q + 1'b1;
                end
            end
            default: begin
                if (rsp_finish) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    // State, counters and frame register; reset discards any partial frame.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            idx_q   <= '0;
            tail_q  <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tail_q  <= tail_d;
            frame_q <= frame_d;
        end
    end

    // Stream outputs decode directly from state; in_data stays zero outside SEND/TAIL.
    always_comb begin
        stream_on   = (state_q == StSend) || (state_q == StTail);
        bus.busy    = (state_q != StIdle);
        bus.r_valid = stream_on;
        bus.in_data = stream_on ? bswap32(word_sel) : 32'h0;
    end

    fc_stream_rsp_capture #(
        .OUTPUT_SIZE (OUTPUT_SIZE),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rsp_capture (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .active_i   (state_q == StWaitRsp),
        .clear_i    (start_acc),
        .t_valid_i  (bus.t_valid),
        .out_data_i (bus.out_data),
        .finish_o   (rsp_finish),
        .done_o     (bus.done),
        .result_o   (bus.result),
        .timeout_o  (bus.timeout)
    );

endmodule
